// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell is reused for
// every bit position, LSB first, with a borrow flop carrying Bout of one
// cycle into Bin of the next. Trades latency (WIDTH+1 cycles per result)
// for a minimal datapath.

// Single-bit full subtractor cell: D = A - B - Bin, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sd_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             d_s;
    logic             bo_s;
    logic [WIDTH-1:0] sd_d;

    full_subtractor u_fs (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .bin_i  (br_q),
        .d_o    (d_s),
        .bout_o (bo_s)
    );

    // Next result-register value: shift right with the new difference bit in at the MSB.
    // Written as a truncated shift of the concatenation so WIDTH=1 needs no special case.
    always_comb begin
        sd_d = WIDTH'({d_s, sd_q} >> 1);
    end

    // Control FSM and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sd_q  <= sd_d;
                    br_q  <= bo_s;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Last bit: publish the full difference and the final borrow.
                        diff_q  <= sd_d;
                        bout_q  <= bo_s;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit unsigned subtractor built around a single full-subtractor cell. A 1-bit borrow register carries Bout back into Bin on the next cycle. The block loads two operands on a start handshake and processes one bit per clock, LSB first. When all bits are done it presents the difference and final borrow with a one-cycle done pulse. It sits directly upstream of the full-subtractor cell: it sequences that cell over wide operands, for datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand and difference width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when diff and bout are updated.
- diff  output  WIDTH  (a - b) mod 2^WIDTH of the last completed operation.
- bout  output  1  final borrow; 1 when a < b (unsigned).

## Operation
- Internal state:
  - shift registers sa, sb (WIDTH bits each).
  - result shift register sd (WIDTH bits).
  - borrow flop br.
  - bit counter cnt of width clog2(WIDTH+1).
  - state register, 2 bits.
- Bit cell: one full_subtractor instance with A = sa[0], B = sb[0], Bin = br.
  - D = A^B^Bin.
  - Bout = (~A&B) | (~(A^B)&Bin).
- FSM states: IDLE, SHIFT.
  - IDLE, start=1: load sa←a, sb←b, br←0, cnt←0; go to SHIFT. busy=1 from the next cycle.
  - IDLE, start=0: hold.
  - SHIFT, each edge:
    - sa and sb shift right by 1.
    - sd shifts right with D entering the MSB.
    - br←Bout, cnt←cnt+1.
  - SHIFT, on the edge where cnt=WIDTH-1 (last bit):
    - diff←{D, sd[WIDTH-1:1]} (the complete result).
    - bout←Bout (the final borrow).
    - done←1, next state IDLE.
- done is registered and high for exactly one cycle; it is 0 in every other cycle.
- diff and bout hold their values until the next completion or reset.
- start while busy=1 is ignored, and a/b changes during SHIFT are ignored.
- start high in the done cycle is accepted, since the state is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- WIDTH=1: SHIFT lasts a single edge, which is both the first and the last bit.
- Width rule: unsigned modular subtraction only. There is no signed overflow flag; bout is the sole out-of-range indicator.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0, internal registers 0.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded.
  - The first start is accepted on the first rising edge with rst_n=1.
- Latency:
  - Start accepted at edge E0.
  - busy=1 after E0.
  - Bits processed at edges E1..EWIDTH.
  - diff, bout and done=1, busy=0 all updated after EWIDTH.
  - done falls after EWIDTH+1.
- busy and done are never high in the same cycle.
- Every output is a register output; no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 with start=1 and random a/b. Required: busy=0, done=0, diff=0x00, bout=0. Release rst_n, then start with a=0x5A, b=0x3C. Required: done exactly 8 edges after the accepting edge, diff=0x1E, bout=0.
- Borrow chain: a=0x00, b=0x01 gives diff=0xFF, bout=1. a=0x80, b=0xFF gives diff=0x81, bout=1. a=b=0xA5 gives diff=0x00, bout=0.
- Ignored start: start with a=0x10, b=0x01. At edge 3 assert start with a=0xFF, b=0xFF and hold it. Required:
  - result diff=0x0F, bout=0;
  - the held start is accepted in the done cycle;
  - the next result is diff=0x00, 9 edges later.
- Mid-operation reset: start a=0xF0, b=0x0F. Pulse rst_n low between edges 4 and 5. Required: busy, done, diff and bout drop to 0 asynchronously. A fresh start a=0x03, b=0x05 then gives diff=0xFE, bout=1.
- Exhaustive WIDTH=1: all 4 (a,b) pairs match D/Bout of the full-subtractor truth table with Bin=0, and done follows 1 edge after acceptance. Also with WIDTH=4: all 256 pairs give diff=(a-b)&0xF, bout=(a<b).
